// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/video single-port RAM arbiter with burst-limited ownership
// Define MEM_ARBITER_ROUND_ROBIN_EN to break IDLE ties round-robin; default gives video priority.

module mem_arbiter #(
   parameter int BURST_MAX = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        c_req,
   input  logic [19:0] c_address,
   input  logic [7:0]  c_wdata,
   input  logic        c_we,
   output logic        c_gnt,
   output logic        c_ready,
   output logic [7:0]  c_rdata,
   input  logic        v_req,
   input  logic [19:0] v_address,
   output logic        v_gnt,
   output logic        v_ready,
   output logic [7:0]  v_rdata,
   output logic [19:0] address,
   output logic [7:0]  o_data,
   output logic        we,
   input  logic [7:0]  i_data
);

   typedef enum logic [1:0] {IDLE, OWN_C, OWN_V} state_t;

   localparam logic       OWNER_C    = 1'b0;
   localparam logic       OWNER_V    = 1'b1;
   localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif

   state_t     state, state_next;
   logic [7:0] burst_cnt;
   logic       last_owner;
   logic       handover;
   logic       other_req;
   logic       access;
   logic       forced;
   logic       both_pick_v;

   always_comb begin
      other_req = 1'b0;
      case (state)
         OWN_C:   other_req = v_req;
         OWN_V:   other_req = c_req;
         default: other_req = 1'b0;
      endcase
   end

   // The first cycle after a forced handover is the dead cycle: no grant is issued.
   assign c_gnt       = (state == OWN_C) & c_req & ~handover;
   assign v_gnt       = (state == OWN_V) & v_req & ~handover;
   assign access      = c_gnt | v_gnt;
   assign forced      = access & other_req & (burst_cnt == BURST_LAST);
   assign both_pick_v = RR_EN ? (last_owner == OWNER_C) : 1'b1;

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (c_req && v_req)
               state_next = both_pick_v ? OWN_V : OWN_C;
            else if (c_req)
               state_next = OWN_C;
            else if (v_req)
               state_next = OWN_V;
         end
         OWN_C: begin
            if (!c_req || forced)
               state_next = v_req ? OWN_V : IDLE;
         end
         OWN_V: begin
            if (!v_req || forced)
               state_next = c_req ? OWN_C : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         burst_cnt  <= 8'd0;
         last_owner <= OWNER_V;
         handover   <= 1'b0;
         c_ready    <= 1'b0;
         v_ready    <= 1'b0;
      end else begin
         state    <= state_next;
         handover <= forced;
         c_ready  <= c_gnt;
         v_ready  <= v_gnt;
         if (state_next != state || !other_req)
            burst_cnt <= 8'd0;
         else if (access)
            burst_cnt <= burst_cnt + 8'd1;
         if (state_next != state) begin
            if (state_next == OWN_C)
               last_owner <= OWNER_C;
            else if (state_next == OWN_V)
               last_owner <= OWNER_V;
         end
      end
   end

   assign address = c_gnt ? c_address : (v_gnt ? v_address : 20'd0);
   assign o_data  = c_gnt ? c_wdata : 8'd0;
   assign we      = c_gnt & c_we;
   assign c_rdata = c_ready ? i_data : 8'd0;
   assign v_rdata = v_ready ? i_data : 8'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a cycle-level reference model
// The RAM stand-in returns address[7:0] + 0x11 one cycle after each address.

module tb_mem_arbiter;

   localparam int BM = 4;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        c_req = 1'b0;
   logic [19:0] c_address = 20'd0;
   logic [7:0]  c_wdata = 8'd0;
   logic        c_we = 1'b0;
   logic        c_gnt, c_ready;
   logic [7:0]  c_rdata;
   logic        v_req = 1'b0;
   logic [19:0] v_address = 20'd0;
   logic        v_gnt, v_ready;
   logic [7:0]  v_rdata;
   logic [19:0] address;
   logic [7:0]  o_data;
   logic        we;
   logic [7:0]  i_data = 8'd0;

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter #(.BURST_MAX(BM)) dut (
      .clock(clock), .reset(reset),
      .c_req(c_req), .c_address(c_address), .c_wdata(c_wdata), .c_we(c_we),
      .c_gnt(c_gnt), .c_ready(c_ready), .c_rdata(c_rdata),
      .v_req(v_req), .v_address(v_address),
      .v_gnt(v_gnt), .v_ready(v_ready), .v_rdata(v_rdata),
      .address(address), .o_data(o_data), .we(we), .i_data(i_data)
   );

   always #5 clock = ~clock;

   always @(posedge clock) i_data <= address[7:0] + 8'h11;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Reference model: owner 0=none 1=C 2=V; served counts accesses while the other side waits.
   int          m_owner = 0;
   int          m_served = 0;
   int          m_prev = 2;
   bit          m_skip = 1'b0;
   bit          m_cr = 1'b0;
   bit          m_vr = 1'b0;
   logic [19:0] m_last_addr = 20'd0;

   initial begin
      @(posedge clock);
      forever begin
         bit          cg, vg, ew, mine, other;
         logic [19:0] ea;
         logic [7:0]  ed;
         int          nxt;
         @(negedge clock);
         cg = (m_owner == 1) && c_req && !m_skip;
         vg = (m_owner == 2) && v_req && !m_skip;
         ea = cg ? c_address : (vg ? v_address : 20'd0);
         ed = cg ? c_wdata : 8'd0;
         ew = cg && c_we;
         chk("m_c_gnt", 32'(c_gnt), 32'(cg));
         chk("m_v_gnt", 32'(v_gnt), 32'(vg));
         chk("m_both_gnt", 32'(c_gnt & v_gnt), 0);
         chk("m_address", 32'(address), 32'(ea));
         chk("m_o_data", 32'(o_data), 32'(ed));
         chk("m_we", 32'(we), 32'(ew));
         chk("m_c_ready", 32'(c_ready), 32'(m_cr));
         chk("m_v_ready", 32'(v_ready), 32'(m_vr));
         chk("m_c_rdata", 32'(c_rdata), m_cr ? 32'(m_last_addr[7:0] + 8'h11) : 0);
         chk("m_v_rdata", 32'(v_rdata), m_vr ? 32'(m_last_addr[7:0] + 8'h11) : 0);
         m_last_addr = ea;
         if (reset) begin
            m_owner = 0; m_served = 0; m_prev = 2; m_skip = 1'b0; m_cr = 1'b0; m_vr = 1'b0;
         end else begin
            m_cr = cg;
            m_vr = vg;
            nxt  = m_owner;
            if (m_owner == 0) begin
               if (c_req && v_req) nxt = RR ? ((m_prev == 1) ? 2 : 1) : 2;
               else if (c_req) nxt = 1;
               else if (v_req) nxt = 2;
               m_served = 0;
               m_skip   = 1'b0;
            end else begin
               mine  = (m_owner == 1) ? c_req : v_req;
               other = (m_owner == 1) ? v_req : c_req;
               if (!mine) begin
                  nxt = other ? 3 - m_owner : 0;
                  m_served = 0;
                  m_skip   = 1'b0;
               end else if (m_skip) begin
                  m_skip = 1'b0;
               end else if (other) begin
                  m_served++;
                  if (m_served == BM) begin
                     nxt = 3 - m_owner;
                     m_served = 0;
                     m_skip   = 1'b1;
                  end
               end else begin
                  m_served = 0;
               end
            end
            if (nxt != 0 && nxt != m_owner) m_prev = nxt;
            m_owner = nxt;
         end
      end
   end

   initial begin
      int first, second, g, e;
      cyc();
      cyc();
      // cycle 0: first cycle out of reset, single CPU write presented
      reset = 1'b0;
      c_req = 1'b1; c_we = 1'b1; c_address = 20'h12345; c_wdata = 8'hA5;
      #1;
      chk("rst_c_gnt", 32'(c_gnt), 0);
      chk("rst_v_gnt", 32'(v_gnt), 0);
      chk("rst_c_ready", 32'(c_ready), 0);
      chk("rst_v_ready", 32'(v_ready), 0);
      chk("rst_we", 32'(we), 0);
      chk("rst_address", 32'(address), 0);
      chk("rst_o_data", 32'(o_data), 0);
      chk("rst_c_rdata", 32'(c_rdata), 0);
      chk("rst_v_rdata", 32'(v_rdata), 0);
      cyc();  // cycle 1
      #1;
      chk("wr_c_gnt", 32'(c_gnt), 1);
      chk("wr_address", 32'(address), 32'h12345);
      chk("wr_we", 32'(we), 1);
      chk("wr_o_data", 32'(o_data), 32'hA5);
      cyc();  // cycle 2
      c_req = 1'b0; c_we = 1'b0; c_address = 20'd0; c_wdata = 8'd0;
      #1;
      chk("wr_c_ready", 32'(c_ready), 1);
      chk("wr_we_after", 32'(we), 0);
      cyc();  // cycle 3
      v_req = 1'b1; v_address = 20'h00100;
      #1;
      chk("wr_c_ready_low", 32'(c_ready), 0);
      for (int i = 0; i < 5; i++) begin
         cyc();  // cycle 4+i
         if (i < 4) v_address = 20'h00100 + 20'(i);
         else v_req = 1'b0;
         #1;
         if (i < 4) begin
            chk($sformatf("vrd_gnt%0d", i), 32'(v_gnt), 1);
            chk($sformatf("vrd_addr%0d", i), 32'(address), 32'h100 + i);
         end
         chk($sformatf("vrd_we%0d", i), 32'(we), 0);
         if (i > 0) begin
            chk($sformatf("vrd_ready%0d", i), 32'(v_ready), 1);
            chk($sformatf("vrd_rdata%0d", i), 32'(v_rdata), 32'h11 + i - 1);
         end
      end
      // Both sides held from IDLE; last owner is V.
      cyc();  // cycle 9
      c_req = 1'b1; v_req = 1'b1; c_we = 1'b0;
      c_address = 20'h0C000; v_address = 20'h0D000;
      first  = RR ? 1 : 2;
      second = 3 - first;
      for (int k = 0; k < 15; k++) begin
         if (k > 0) cyc();
         #1;
         g = c_gnt ? 1 : (v_gnt ? 2 : 0);
         e = (k == 0 || k == 5 || k == 10) ? 0 : ((k < 5 || k > 10) ? first : second);
         chk($sformatf("burst%0d", k), 32'(g), 32'(e));
      end
      cyc();  // cycle 24
      c_req = 1'b0; v_req = 1'b0;
      cyc();  // cycle 25
      v_req = 1'b1; v_address = 20'h00200;
      cyc();  // cycle 26
      c_req = 1'b1; c_we = 1'b1; c_address = 20'hABCDE; c_wdata = 8'h3C;
      #1;
      chk("drop_v_gnt", 32'(v_gnt), 1);
      cyc();  // cycle 27
      v_req = 1'b0;
      #1;
      chk("drop_v_ready", 32'(v_ready), 1);
      chk("drop_dead_c", 32'(c_gnt), 0);
      cyc();  // cycle 28
      reset = 1'b1;
      #1;
      chk("drop_c_gnt", 32'(c_gnt), 1);
      chk("drop_c_we", 32'(we), 1);
      chk("drop_c_addr", 32'(address), 32'hABCDE);
      cyc();  // cycle 29
      reset = 1'b0; c_req = 1'b0; c_we = 1'b0;
      #1;
      chk("abort_c_ready", 32'(c_ready), 0);
      chk("abort_we", 32'(we), 0);
      chk("abort_c_gnt", 32'(c_gnt), 0);
      chk("abort_address", 32'(address), 0);
      cyc();  // cycle 30
      c_req = 1'b1; c_address = 20'h00042;
      for (int k = 0; k < 12; k++) begin
         cyc();  // cycle 31+k
         if (k == 5) v_req = 1'b1;
         #1;
         g = c_gnt ? 1 : (v_gnt ? 2 : 0);
         e = (k <= 8) ? 1 : ((k == 9) ? 0 : 2);
         chk($sformatf("solo%0d", k), 32'(g), 32'(e));
      end
      cyc();
      c_req = 1'b0; v_req = 1'b0;
      repeat (3) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
